// File: rtl/bist_controller.sv
// Logic BIST engine: LFSR patterns drive the CUT, a MISR compacts its response, and the result is checked against a golden signature.
// Latency: bistdone rises N_PATTERNS+2 edges after reset release while bistmode is held; pi->cut_pi and cut_po->po are combinational.
// Backpressure: none; dropping bistmode aborts a run, and reset is the only way out of DONE.
module bist_controller #(
  parameter int              N_PI       = 35,
  parameter int              N_PO       = 49,
  parameter int              N_PATTERNS = 2000,
  parameter logic [N_PI-1:0] LFSR_SEED  = 35'h0_0000_0001,
  parameter logic [N_PI-1:0] LFSR_POLY  = 35'h5_0000_0000,
  parameter logic [N_PO-1:0] MISR_POLY  = 49'h1_0000_0000_0201,
  parameter logic [N_PO-1:0] GOLDEN_SIG = 49'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bistmode,
  input  logic [N_PI-1:0] pi,
  output logic [N_PI-1:0] cut_pi,
  input  logic [N_PO-1:0] cut_po,
  output logic [N_PO-1:0] po,
  output logic            bistdone,
  output logic            bistpass
);

  localparam int CW = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_PATTERNS - 1);
  // An all-zero seed would lock the LFSR at zero.
  localparam logic [N_PI-1:0] SEED = (LFSR_SEED == '0) ? N_PI'(1) : LFSR_SEED;

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t          state_q, state_d;
  logic [N_PI-1:0] lfsr_q, lfsr_d;
  logic [N_PO-1:0] misr_q, misr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (bistmode) begin
          state_d = RUN;
          lfsr_d  = SEED;
          misr_d  = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Abort discards the partial signature; the next run reloads everything.
        if (!bistmode) begin
          state_d = IDLE;
        end else begin
          misr_d = {misr_q[N_PO-2:0], 1'b0} ^ (misr_q[N_PO-1] ? MISR_POLY : '0) ^ cut_po;
          lfsr_d = {lfsr_q[N_PI-2:0], 1'b0} ^ (lfsr_q[N_PI-1] ? LFSR_POLY : '0);
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = CHECK;
        end
      end
      CHECK: begin
        pass_d  = (misr_q == GOLDEN_SIG);
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cut_pi   = (state_q == RUN) ? lfsr_q : pi;
  assign po       = cut_po;
  assign bistdone = done_q;
  assign bistpass = pass_q;

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: random pins against a pattern/signature reference model.
module tb_bist_controller;

  localparam int NP = 50;
  localparam logic [34:0] SEED  = 35'h1;
  localparam logic [34:0] LPOLY = 35'h5_0000_0000;
  localparam logic [48:0] MPOLY = 49'h1_0000_0000_0201;

  function automatic logic [34:0] lfsr_next(input logic [34:0] x);
    logic [34:0] r;
    r = x << 1;
    if (x[34]) r = r ^ LPOLY;
    return r;
  endfunction

  // Stand-in CUT: an arbitrary but fixed combinational function.
  function automatic logic [48:0] cut_fn(input logic [34:0] x);
    return {x[13:0], x} ^ (49'(x) * 49'h1F2);
  endfunction

  function automatic logic [48:0] sig_calc(input logic stuck_v);
    logic [34:0] l;
    logic [48:0] m;
    logic [48:0] r;
    l = SEED;
    m = '0;
    for (int k = 0; k < NP; k++) begin
      r = cut_fn(l);
      if (stuck_v) r[0] = 1'b0;
      m = (m << 1) ^ (m[48] ? MPOLY : 49'h0) ^ r;
      l = lfsr_next(l);
    end
    return m;
  endfunction

  localparam logic [48:0] GOLD = sig_calc(1'b0);

  logic        clk = 1'b0;
  logic        rst, bistmode, rst6, bistmode6, stuck;
  logic [34:0] pi, cut_pi, cut_pi6;
  logic [48:0] cut_po, po, cut_po6, po6;
  logic        bistdone, bistpass, bistdone6, bistpass6;
  int          total = 0;
  int          bad = 0;
  logic [34:0] lf_tab [NP];

  always #5 clk = ~clk;

  assign cut_po  = cut_fn(cut_pi) & ~{48'h0, stuck};
  assign cut_po6 = cut_fn(cut_pi6);

  bist_controller #(.N_PATTERNS(NP), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD)) dut (
    .clk(clk), .rst(rst), .bistmode(bistmode), .pi(pi), .cut_pi(cut_pi),
    .cut_po(cut_po), .po(po), .bistdone(bistdone), .bistpass(bistpass));

  bist_controller #(.N_PATTERNS(4), .LFSR_SEED(35'h1)) u6 (
    .clk(clk), .rst(rst6), .bistmode(bistmode6), .pi(pi), .cut_pi(cut_pi6),
    .cut_po(cut_po6), .po(po6), .bistdone(bistdone6), .bistpass(bistpass6));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pi();
    pi = 35'({$urandom(), $urandom()});
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rand_pi();
    #1;
    chk("rst_done", 64'(bistdone), 64'd0);
    chk("rst_pass", 64'(bistpass), 64'd0);
    chk("rst_cut_pi", 64'(cut_pi), 64'(pi));
  endtask

  // Edge e=1 leaves IDLE, edges 2..NP+1 capture pattern e-2, edge NP+2 leaves CHECK.
  task automatic run_edges(input int n);
    logic [34:0] exp_pi;
    logic [48:0] exp_po;
    for (int e = 1; e <= n; e++) begin
      rand_pi();
      #1;
      exp_pi = (e >= 2 && e <= NP + 1) ? lf_tab[e-2] : pi;
      exp_po = cut_fn(exp_pi) & ~{48'h0, stuck};
      chk("run_cut_pi", 64'(cut_pi), 64'(exp_pi));
      chk("run_po", 64'(po), 64'(exp_po));
      chk("run_done_low", 64'(bistdone), 64'd0);
      tick();
    end
  endtask

  task automatic full_run(input logic exp_pass);
    run_edges(NP + 2);
    chk("end_done", 64'(bistdone), 64'd1);
    chk("end_pass", 64'(bistpass), 64'(exp_pass));
  endtask

  initial begin
    logic [34:0] l;
    int r;
    l = SEED;
    for (int k = 0; k < NP; k++) begin
      lf_tab[k] = l;
      l = lfsr_next(l);
    end
    rst = 1'b1; bistmode = 1'b1; stuck = 1'b0; pi = '0;
    rst6 = 1'b1; bistmode6 = 1'b0;

    // Fault-free run, then DONE holds through bistmode toggling
    reset_dut();
    full_run(1'b1);
    for (int i = 0; i < 20; i++) begin
      bistmode = ($urandom_range(0, 1) == 1);
      rand_pi();
      tick();
      chk("done_hold", 64'(bistdone), 64'd1);
      chk("pass_hold", 64'(bistpass), 64'd1);
      chk("done_cut_pi", 64'(cut_pi), 64'(pi));
    end

    // Back-to-back run after a one-cycle reset
    bistmode = 1'b1;
    reset_dut();
    full_run(1'b1);

    // Stuck-at-0 on cut_po[0]
    stuck = 1'b1;
    reset_dut();
    full_run(sig_calc(1'b1) == GOLD);
    stuck = 1'b0;

    // Passthrough
    bistmode = 1'b0;
    reset_dut();
    pi = 35'h5_5555_5555;
    #1;
    chk("pass_thru_5555", 64'(cut_pi), 64'h5_5555_5555);
    chk("pass_thru_po", 64'(po), 64'(cut_fn(35'h5_5555_5555)));
    for (int i = 0; i < 5000; i++) begin
      tick();
      chk("pass_thru_done", 64'(bistdone), 64'd0);
      if (i % 50 == 0) begin
        rand_pi();
        #1;
        chk("pass_thru_pi", 64'(cut_pi), 64'(pi));
        chk("pass_thru_po2", 64'(po), 64'(cut_fn(pi)));
      end
    end

    // Reset at a random point mid-run, then a complete restart
    bistmode = 1'b1;
    for (int t = 0; t < 3; t++) begin
      r = $urandom_range(5, NP - 5);
      reset_dut();
      run_edges(r + 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_done", 64'(bistdone), 64'd0);
      full_run(1'b1);
    end

    // Abort after 10 captures, then a fresh run from IDLE
    reset_dut();
    run_edges(11);
    bistmode = 1'b0;
    tick();
    rand_pi();
    #1;
    chk("abort_cut_pi", 64'(cut_pi), 64'(pi));
    chk("abort_done", 64'(bistdone), 64'd0);
    tick();
    chk("abort_idle_done", 64'(bistdone), 64'd0);
    bistmode = 1'b1;
    full_run(1'b1);

    // Short run: exact LFSR sequence and bistdone timing
    rst6 = 1'b1;
    tick();
    rst6 = 1'b0;
    bistmode6 = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      rand_pi();
      #1;
      if (e >= 2 && e <= 5) chk("t6_lfsr", 64'(cut_pi6), 64'(35'h1 << (e - 2)));
      else chk("t6_pi", 64'(cut_pi6), 64'(pi));
      chk("t6_done_low", 64'(bistdone6), 64'd0);
      tick();
    end
    chk("t6_done_edge6", 64'(bistdone6), 64'd1);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("t6_done_hold", 64'(bistdone6), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
